// File: rtl/fp_divsqrt_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// fp_divsqrt_arbiter_pkg
// Shared configuration and recovery types for the FP divide/sqrt arbiter:
//   - sizing of lanes, units and active-list pointers
//   - DivSqrtUnitIndexPath unit index type
//   - flush descriptor and the Flushed() range test used by every consumer
// -----------------------------------------------------------------------------
package fp_divsqrt_arbiter_pkg;

  localparam int NUM_REQ    = 2;  // requesting issue lanes
  localparam int NUM_UNITS  = 2;  // FP_DIVSQRT_ISSUE_WIDTH
  localparam int AL_W       = 6;  // active-list index width

  localparam int UNIT_IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int LANE_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef logic [AL_W-1:0]       al_ptr_t;
  typedef logic [UNIT_IDX_W-1:0] DivSqrtUnitIndexPath;
  typedef logic [LANE_IDX_W-1:0] lane_idx_t;

  typedef struct packed {
    logic    valid;     // selective flush of [head, tail)
    logic    all;       // flush everything
    al_ptr_t head;
    al_ptr_t tail;
  } flush_t;

  // Range [head, tail) on the circular active list; head == tail is empty.
  function automatic logic flushed(input flush_t f, input al_ptr_t ptr);
    logic hit;
    hit = 1'b0;
    if (f.all) begin
      hit = 1'b1;
    end else if (f.valid) begin
      if (f.head < f.tail)      hit = (ptr >= f.head) && (ptr < f.tail);
      else if (f.head > f.tail) hit = (ptr >= f.head) || (ptr < f.tail);
    end
    return hit;
  endfunction

endpackage

// File: rtl/fp_divsqrt_arbiter_if.sv
// -----------------------------------------------------------------------------
// fp_divsqrt_arbiter_if
// Issue-stage bundle between the issue lanes / div-sqrt units and the arbiter.
//   slave  : the arbiter (consumes i_*, drives o_*)
//   master : the surrounding pipeline (drives i_*, observes o_*)
// Signals:
//   i_req, i_req_ptr          lane requests and their active-list indices
//   i_unit_free               unit is free next cycle
//   i_unit_finished           unit holds a completed result
//   i_release                 owner consumed the result
//   i_flush_*                 selective / total flush, range [head, tail)
//   o_grant, o_grant_unit     per-lane grant and granted unit
//   o_acquire, o_acquire_ptr  per-unit acquire strobe and op index
//   o_notify, o_notify_unit   per-lane finished notification
//   o_owner_valid             registered ownership per unit
// -----------------------------------------------------------------------------
interface fp_divsqrt_arbiter_if;
  import fp_divsqrt_arbiter_pkg::*;

  logic [NUM_REQ-1:0]                    i_req;
  al_ptr_t [NUM_REQ-1:0]                 i_req_ptr;
  logic [NUM_UNITS-1:0]                  i_unit_free;
  logic [NUM_UNITS-1:0]                  i_unit_finished;
  logic [NUM_UNITS-1:0]                  i_release;
  logic                                  i_flush_valid;
  logic                                  i_flush_all;
  al_ptr_t                               i_flush_head;
  al_ptr_t                               i_flush_tail;
  logic [NUM_REQ-1:0]                    o_grant;
  DivSqrtUnitIndexPath [NUM_REQ-1:0]     o_grant_unit;
  logic [NUM_UNITS-1:0]                  o_acquire;
  al_ptr_t [NUM_UNITS-1:0]               o_acquire_ptr;
  logic [NUM_REQ-1:0]                    o_notify;
  DivSqrtUnitIndexPath [NUM_REQ-1:0]     o_notify_unit;
  logic [NUM_UNITS-1:0]                  o_owner_valid;

  modport slave (
    input  i_req, i_req_ptr, i_unit_free, i_unit_finished, i_release,
           i_flush_valid, i_flush_all, i_flush_head, i_flush_tail,
    output o_grant, o_grant_unit, o_acquire, o_acquire_ptr,
           o_notify, o_notify_unit, o_owner_valid
  );

  modport master (
    output i_req, i_req_ptr, i_unit_free, i_unit_finished, i_release,
           i_flush_valid, i_flush_all, i_flush_head, i_flush_tail,
    input  o_grant, o_grant_unit, o_acquire, o_acquire_ptr,
           o_notify, o_notify_unit, o_owner_valid
  );
endinterface

// File: rtl/fp_divsqrt_owner_entry.sv
// -----------------------------------------------------------------------------
// fp_divsqrt_owner_entry
// Owner registers of one div/sqrt unit: which lane and active-list entry own it.
// Ports:
//   clk, rst          clock, async active-high reset
//   i_set             new grant to this unit this cycle (wins over clear)
//   i_set_lane/ptr    owner recorded on i_set
//   i_release         owner consumed the result
//   i_flush           current flush descriptor
//   o_valid, o_lane   registered owner state
//   o_vacating        owned and released or flushed this cycle
// -----------------------------------------------------------------------------
module fp_divsqrt_owner_entry
  import fp_divsqrt_arbiter_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      i_set,
  input  lane_idx_t i_set_lane,
  input  al_ptr_t   i_set_ptr,
  input  logic      i_release,
  input  flush_t    i_flush,
  output logic      o_valid,
  output lane_idx_t o_lane,
  output logic      o_vacating
);

  logic      r_valid;
  lane_idx_t r_lane;
  al_ptr_t   r_ptr;

  assign o_valid    = r_valid;
  assign o_lane     = r_lane;
  // A release on an unowned unit is meaningless, so qualify with r_valid.
  assign o_vacating = r_valid & (i_release | flushed(i_flush, r_ptr));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_lane  <= '0;
      r_ptr   <= '0;
    end else if (i_set) begin
      r_valid <= 1'b1;
      r_lane  <= i_set_lane;
      r_ptr   <= i_set_ptr;
    end else if (o_vacating) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fp_divsqrt_arbiter.sv
// -----------------------------------------------------------------------------
// fp_divsqrt_arbiter
// Shares NUM_UNITS divide/sqrt units among NUM_REQ issue lanes. Free units are
// granted round-robin over lanes in the issue stage (combinational), the
// owning lane/op is recorded per unit, finished units are routed back to their
// owner, and ownership is dropped on release or selective flush.
// Ports:
//   clk   clock
//   rst   async active-high reset; forces grant/acquire/notify low
//   bus   fp_divsqrt_arbiter_if.slave (see interface header)
// -----------------------------------------------------------------------------
module fp_divsqrt_arbiter
  import fp_divsqrt_arbiter_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  fp_divsqrt_arbiter_if.slave bus
);

  flush_t                            w_flush;
  logic [NUM_UNITS-1:0]              w_owner_valid;
  lane_idx_t                         w_owner_lane [NUM_UNITS];
  logic [NUM_UNITS-1:0]              w_vacating;
  logic [NUM_UNITS-1:0]              w_eligible;
  logic [NUM_REQ-1:0]                w_grant;
  DivSqrtUnitIndexPath [NUM_REQ-1:0] w_grant_unit;
  logic [NUM_UNITS-1:0]              w_acquire;
  al_ptr_t [NUM_UNITS-1:0]           w_acquire_ptr;
  lane_idx_t                         w_set_lane [NUM_UNITS];
  logic                              w_any_grant;
  lane_idx_t                         w_last_lane;
  logic [NUM_REQ-1:0]                w_notify;
  DivSqrtUnitIndexPath [NUM_REQ-1:0] w_notify_unit;
  lane_idx_t                         r_rr_ptr;

  assign w_flush = '{valid: bus.i_flush_valid, all: bus.i_flush_all,
                     head: bus.i_flush_head, tail: bus.i_flush_tail};

  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_owner
    fp_divsqrt_owner_entry u_entry (
      .clk        (clk),
      .rst        (rst),
      .i_set      (w_acquire[u]),
      .i_set_lane (w_set_lane[u]),
      .i_set_ptr  (w_acquire_ptr[u]),
      .i_release  (bus.i_release[u]),
      .i_flush    (w_flush),
      .o_valid    (w_owner_valid[u]),
      .o_lane     (w_owner_lane[u]),
      .o_vacating (w_vacating[u])
    );
  end

  // A unit being released/flushed this cycle can be handed out again at once.
  assign w_eligible = bus.i_unit_free & (~w_owner_valid | w_vacating);

  // Round-robin allocator: lanes from r_rr_ptr upward, each taking the
  // lowest eligible unit not already taken this cycle.
  // NOTE: every variable written here gets a default first so no latch is
  // inferred on paths where a lane or unit is skipped.
  always_comb begin
    w_grant       = '0;
    w_grant_unit  = '0;
    w_acquire     = '0;
    w_acquire_ptr = '0;
    w_any_grant   = 1'b0;
    w_last_lane   = '0;
    for (int u = 0; u < NUM_UNITS; u++) w_set_lane[u] = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      automatic int   l     = (int'(r_rr_ptr) + k) % NUM_REQ;
      automatic logic found = 1'b0;
      if (bus.i_req[l] && !flushed(w_flush, bus.i_req_ptr[l])) begin
        for (int u = 0; u < NUM_UNITS; u++) begin
          if (!found && w_eligible[u] && !w_acquire[u]) begin
            found            = 1'b1;
            w_acquire[u]     = 1'b1;
            w_acquire_ptr[u] = bus.i_req_ptr[l];
            w_set_lane[u]    = lane_idx_t'(l);
            w_grant[l]       = 1'b1;
            w_grant_unit[l]  = DivSqrtUnitIndexPath'(u);
            w_any_grant      = 1'b1;
            w_last_lane      = lane_idx_t'(l);
          end
        end
      end
    end
  end

  // Lowest-index finished unit owned by each lane; descending scan so the
  // lowest match is written last.
  always_comb begin
    w_notify      = '0;
    w_notify_unit = '0;
    for (int l = 0; l < NUM_REQ; l++) begin
      for (int u = NUM_UNITS - 1; u >= 0; u--) begin
        if (w_owner_valid[u] && bus.i_unit_finished[u] &&
            w_owner_lane[u] == lane_idx_t'(l)) begin
          w_notify[l]      = 1'b1;
          w_notify_unit[l] = DivSqrtUnitIndexPath'(u);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_any_grant) begin
      r_rr_ptr <= lane_idx_t'((int'(w_last_lane) + 1) % NUM_REQ);
    end
  end

  assign bus.o_grant       = rst ? '0 : w_grant;
  assign bus.o_grant_unit  = w_grant_unit;
  assign bus.o_acquire     = rst ? '0 : w_acquire;
  assign bus.o_acquire_ptr = w_acquire_ptr;
  assign bus.o_notify      = rst ? '0 : w_notify;
  assign bus.o_notify_unit = w_notify_unit;
  assign bus.o_owner_valid = w_owner_valid;

endmodule

// File: tb/tb_fp_divsqrt_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fp_divsqrt_arbiter
// Directed scenarios followed by random traffic, all compared against a
// behavioural ownership model built from plain integer arrays.
// -----------------------------------------------------------------------------
module tb_fp_divsqrt_arbiter;
  import fp_divsqrt_arbiter_pkg::*;

  localparam int NR = NUM_REQ;
  localparam int NU = NUM_UNITS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_divsqrt_arbiter_if bus ();

  fp_divsqrt_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference state: who owns each unit, and which lane is visited first.
  bit m_valid [NU];
  int m_lane  [NU];
  int m_ptr   [NU];
  int m_rr;
  bit n_valid [NU];
  int n_lane  [NU];
  int n_ptr   [NU];
  int n_rr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit m_flushed(input int p);
    int h, t;
    h = int'(bus.i_flush_head);
    t = int'(bus.i_flush_tail);
    if (bus.i_flush_all) return 1'b1;
    if (!bus.i_flush_valid) return 1'b0;
    if (h < t) return (p >= h) && (p < t);
    if (h > t) return (p >= h) || (p < t);
    return 1'b0;
  endfunction

  function automatic logic [NU-1:0] m_owner_vec();
    logic [NU-1:0] v;
    for (int u = 0; u < NU; u++) v[u] = m_valid[u];
    return v;
  endfunction

  task automatic clear_inputs();
    bus.i_req = '0;
    bus.i_req_ptr = '0;
    bus.i_unit_free = '0;
    bus.i_unit_finished = '0;
    bus.i_release = '0;
    bus.i_flush_valid = 1'b0;
    bus.i_flush_all = 1'b0;
    bus.i_flush_head = '0;
    bus.i_flush_tail = '0;
  endtask

  task automatic model_reset();
    for (int u = 0; u < NU; u++) begin
      m_valid[u] = 1'b0; m_lane[u] = 0; m_ptr[u] = 0;
    end
    m_rr = 0;
  endtask

  // Settle combinational outputs, compare them to the model, prepare next state.
  task automatic settle_check();
    logic [NR-1:0] e_grant;
    logic [NU-1:0] e_acq;
    logic [NR-1:0] e_notify;
    int e_gunit [NR];
    int e_aptr  [NU];
    int e_nunit [NR];
    int last;
    #1;
    e_grant = '0; e_acq = '0; e_notify = '0; last = -1;
    for (int i = 0; i < NR; i++) begin e_gunit[i] = 0; e_nunit[i] = 0; end
    for (int i = 0; i < NU; i++) e_aptr[i] = 0;
    for (int k = 0; k < NR; k++) begin
      int l;
      l = (m_rr + k) % NR;
      if (bus.i_req[l] && !m_flushed(int'(bus.i_req_ptr[l]))) begin
        for (int u = 0; u < NU; u++) begin
          if (!e_acq[u] && bus.i_unit_free[u] &&
              (!m_valid[u] || bus.i_release[u] || m_flushed(m_ptr[u]))) begin
            e_acq[u] = 1'b1; e_aptr[u] = int'(bus.i_req_ptr[l]);
            e_grant[l] = 1'b1; e_gunit[l] = u; last = l;
            break;
          end
        end
      end
    end
    for (int l = 0; l < NR; l++) begin
      for (int u = 0; u < NU; u++) begin
        if (m_valid[u] && m_lane[u] == l && bus.i_unit_finished[u]) begin
          e_notify[l] = 1'b1; e_nunit[l] = u;
          break;
        end
      end
    end
    check("owner_valid", 32'(bus.o_owner_valid), 32'(m_owner_vec()));
    check("grant", 32'(bus.o_grant), 32'(e_grant));
    check("acquire", 32'(bus.o_acquire), 32'(e_acq));
    check("notify", 32'(bus.o_notify), 32'(e_notify));
    for (int l = 0; l < NR; l++) begin
      if (e_grant[l]) check($sformatf("grant_unit[%0d]", l), 32'(bus.o_grant_unit[l]), 32'(e_gunit[l]));
      if (e_notify[l]) check($sformatf("notify_unit[%0d]", l), 32'(bus.o_notify_unit[l]), 32'(e_nunit[l]));
    end
    for (int u = 0; u < NU; u++)
      if (e_acq[u]) check($sformatf("acquire_ptr[%0d]", u), 32'(bus.o_acquire_ptr[u]), 32'(e_aptr[u]));
    n_rr = (last >= 0) ? (last + 1) % NR : m_rr;
    for (int u = 0; u < NU; u++) begin
      n_valid[u] = m_valid[u]; n_lane[u] = m_lane[u]; n_ptr[u] = m_ptr[u];
      if (e_acq[u]) begin
        n_valid[u] = 1'b1; n_ptr[u] = e_aptr[u];
        for (int l = 0; l < NR; l++) if (e_grant[l] && e_gunit[l] == u) n_lane[u] = l;
      end else if (m_valid[u] && (bus.i_release[u] || m_flushed(m_ptr[u]))) begin
        n_valid[u] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int u = 0; u < NU; u++) begin
      m_valid[u] = n_valid[u]; m_lane[u] = n_lane[u]; m_ptr[u] = n_ptr[u];
    end
    m_rr = n_rr;
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic step();
    settle_check();
    tick();
  endtask

  // Synchronous-looking reset applied from a negedge; outputs checked while held.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_owner_valid", 32'(bus.o_owner_valid), 32'd0);
    check("rst_grant", 32'(bus.o_grant), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    model_reset();
    @(negedge clk);
    do_reset();

    // Single grant: lane 0, ptr 5, both units free.
    bus.i_req = 2'b01; bus.i_req_ptr[0] = 6'd5; bus.i_unit_free = 2'b11;
    settle_check();
    check("single_grant", 32'(bus.o_grant), 32'b01);
    check("single_acq_ptr0", 32'(bus.o_acquire_ptr[0]), 32'd5);
    tick();
    settle_check();
    check("single_owner", 32'(bus.o_owner_valid), 32'b01);
    tick();

    // Contention: only unit 1 free, rr at lane 0, then lane 1 wins.
    do_reset();
    bus.i_req = 2'b11; bus.i_req_ptr = {6'd11, 6'd10}; bus.i_unit_free = 2'b10;
    settle_check();
    check("contend_lane0", 32'(bus.o_grant), 32'b01);
    check("contend_unit1", 32'(bus.o_grant_unit[0]), 32'd1);
    tick();
    bus.i_req = 2'b11; bus.i_req_ptr = {6'd13, 6'd12}; bus.i_unit_free = 2'b10;
    bus.i_release = 2'b10;
    settle_check();
    check("contend_lane1", 32'(bus.o_grant), 32'b10);
    tick();

    // Dual grant.
    do_reset();
    bus.i_req = 2'b11; bus.i_req_ptr = {6'd4, 6'd3}; bus.i_unit_free = 2'b11;
    settle_check();
    check("dual_acq_ptr", 32'(bus.o_acquire_ptr), 32'({6'd4, 6'd3}));
    tick();

    // Notify / release with same-cycle regrant.
    do_reset();
    bus.i_req = 2'b10; bus.i_req_ptr[1] = 6'd7; bus.i_unit_free = 2'b01;
    step();
    bus.i_unit_finished = 2'b01;
    settle_check();
    check("notify_lane1", 32'(bus.o_notify), 32'b10);
    tick();
    bus.i_unit_finished = 2'b01; bus.i_release = 2'b01;
    bus.i_req = 2'b01; bus.i_req_ptr[0] = 6'd9; bus.i_unit_free = 2'b01;
    settle_check();
    check("regrant_lane0", 32'(bus.o_grant), 32'b01);
    tick();
    bus.i_unit_finished = 2'b01;
    settle_check();
    check("notify_new_owner", 32'(bus.o_notify), 32'b01);
    tick();

    // Wrap flush.
    do_reset();
    bus.i_req = 2'b11; bus.i_req_ptr = {6'd2, 6'd62}; bus.i_unit_free = 2'b11;
    step();
    bus.i_flush_valid = 1'b1; bus.i_flush_head = 6'd60; bus.i_flush_tail = 6'd1;
    bus.i_req = 2'b01; bus.i_req_ptr[0] = 6'd63; bus.i_unit_free = 2'b11;
    settle_check();
    check("flush_no_grant", 32'(bus.o_grant), 32'd0);
    tick();
    settle_check();
    check("flush_owner", 32'(bus.o_owner_valid), 32'b10);
    tick();

    // Move rr to lane 1, then async reset between edges.
    bus.i_req = 2'b01; bus.i_req_ptr[0] = 6'd20; bus.i_unit_free = 2'b01;
    step();
    bus.i_req = 2'b11; bus.i_unit_free = 2'b11; bus.i_unit_finished = 2'b11;
    #2 rst = 1'b1;
    #1;
    check("async_owner", 32'(bus.o_owner_valid), 32'd0);
    check("async_grant", 32'(bus.o_grant), 32'd0);
    check("async_acquire", 32'(bus.o_acquire), 32'd0);
    check("async_notify", 32'(bus.o_notify), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    bus.i_req = 2'b11; bus.i_unit_free = 2'b01;
    settle_check();
    check("rr_after_reset", 32'(bus.o_grant), 32'b01);
    tick();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      bus.i_req = 2'($urandom);
      bus.i_req_ptr = {6'($urandom), 6'($urandom)};
      bus.i_unit_free = 2'($urandom);
      bus.i_unit_finished = 2'($urandom);
      bus.i_release = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      bus.i_flush_valid = ($urandom_range(0, 7) == 0);
      bus.i_flush_all = ($urandom_range(0, 31) == 0);
      bus.i_flush_head = 6'($urandom);
      bus.i_flush_tail = 6'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fp_divsqrt_arbiter.md
# fp_divsqrt_arbiter

Shares the FP_DIVSQRT_ISSUE_WIDTH floating-point divide/sqrt units among several issue lanes. In the issue stage it grants free units to requesting lanes round-robin and drives each unit's acquire. It records which lane and active-list entry owns each unit, routes finished notifications back to the owning lane, and drops ownership on release or selective flush.

## Interface
- NUM_REQ, 2, number of requesting issue lanes
- NUM_UNITS, 2, number of div/sqrt units (equals FP_DIVSQRT_ISSUE_WIDTH)
- AL_W, 6, active-list index width
- clk  in  1  clock
- rst  in  1  reset; asynchronous and active-high
- req  in  NUM_REQ  lane requests a unit this cycle
- reqPtr  in  NUM_REQ×AL_W  active-list index of requesting op
- unitFree  in  NUM_UNITS  unit reports it is free next cycle
- unitFinished  in  NUM_UNITS  unit holds a completed result
- release  in  NUM_UNITS  owner has consumed the result
- flushValid, flushAll  in  1 each  selective / total flush this cycle
- flushHead, flushTail  in  AL_W each  flush range [head, tail)
- grant  out  NUM_REQ  lane's request accepted (combinational)
- grantUnit  out  NUM_REQ×clog2(NUM_UNITS)  unit given to lane
- acquire  out  NUM_UNITS  acquire strobe to unit
- acquirePtr  out  NUM_UNITS×AL_W  active-list index passed with acquire
- notify  out  NUM_REQ  owned unit of this lane is finished
- notifyUnit  out  NUM_REQ×clog2(NUM_UNITS)  which unit finished
- ownerValid  out  NUM_UNITS  unit currently owned (registered)

## Operation
- State per unit: ownerValid, ownerLane, ownerPtr. There is also one round-robin pointer rrPtr over lanes.
- Flushed(ptr): true if flushAll is set. Otherwise, when flushValid is set:
  - head<tail: head≤ptr<tail.
  - head>tail (wrap): ptr≥head or ptr<tail.
  - head==tail: empty range.
- Eligible(u) = unitFree[u] and (!ownerValid[u] or release[u] or Flushed(ownerPtr[u])).
- Lane l participates only if req[l] is set and Flushed(reqPtr[l]) is false.
- Allocation:
  - Visit participating lanes in order rrPtr, rrPtr+1, … mod NUM_REQ.
  - Each visited lane takes the lowest-index eligible unit not yet taken this cycle.
  - At most one unit per lane and one lane per unit.
- On a grant to lane l of unit u:
  - grant[l]=1, grantUnit[l]=u, acquire[u]=1, acquirePtr[u]=reqPtr[l].
  - Next cycle: ownerValid[u]=1, ownerLane[u]=l, ownerPtr[u]=reqPtr[l].
- rrPtr moves to (last granted lane + 1) mod NUM_REQ. If nothing was granted, rrPtr holds.
- notify[l] is set when some owned unit u has ownerLane[u]==l and unitFinished[u]. notifyUnit gives the lowest such u.
- Ownership is cleared next cycle on release[u], or when Flushed(ownerPtr[u]) is true, unless a new grant to u happens in the same cycle.
- Priority on a single unit in one cycle: new grant > clear > hold.
- release on an unowned unit is ignored.
- An illegal unitFinished on an unowned unit produces no notify.

## Timing
- Reset (async, immediate): ownerValid=0, ownerLane=0, ownerPtr=0, rrPtr=0.
  - While rst is high, grant, acquire, and notify are forced to 0.
- grant, acquire, acquirePtr: combinational, same cycle as req (issue stage). They must settle within the issue-stage budget.
- ownerValid: registered, 1 cycle after grant.
- notify: combinational from the registered owner state and unitFinished. It stays asserted until release or flush.
- Back-to-back reuse of a unit: a release in cycle N allows a grant to the same unit in cycle N, provided unitFree[u]=1.
- A flush in the same cycle as a request of a flushed op: no grant, no acquire, rrPtr unchanged.

## Structure
- A Flushed() helper lives in the shared recovery-types package next to the existing selective-flush range logic; the range semantics are identical.
- DivSqrtUnitIndexPath typedef (clog2 of FP_DIVSQRT_ISSUE_WIDTH) goes in the micro-architecture configuration package.
- Sub-module: fp_divsqrt_owner_entry holds one unit's owner registers and clear/set logic. It is instantiated NUM_UNITS times.
- The allocator (round-robin lane loop, lowest-free-unit pick) stays in the top module.

## Test plan
- Single grant: reset, then req[0]=1, reqPtr=5, both units free → grant[0]=1, grantUnit=0, acquire[0]=1, acquirePtr[0]=5; next cycle ownerValid=2'b01.
- Contention: req=2'b11, only unit 1 free, rrPtr=0 → lane 0 gets unit 1. Repeat with unit 1 free again → lane 1 wins (rrPtr=1).
- Dual grant: req=2'b11, ptrs 3 and 4, both free → lane 0 gets unit 0 and lane 1 gets unit 1; acquirePtr={4,3}.
- Notify/release: unit 0 owned by lane 1. unitFinished[0]=1 → notify[1]=1, notifyUnit=0. release[0]=1 plus req[0] in the same cycle → new grant of unit 0 to lane 0.
- Wrap flush: owners with ptr 62 and 2, flushHead=60, flushTail=1 → only the ptr-62 entry is cleared next cycle. A request with ptr 63 in that cycle → no grant.
- Async reset mid-operation: assert rst between clock edges while units are owned → ownerValid=0 immediately, all outputs 0, rrPtr=0 after deassert.
